p2s_lane_serializer: RTL and testbench

Parametrised parallel-to-serial converter: accepts an N-bit word on a valid/ready parallel port and emits it as N/W beats of W bits on a valid/ready serial port. It is the next-generation p2s block in the datapath. Over the single-bit converter it adds a configurable lane width, a selectable bit order and a one-word hold buffer, so back-to-back words stream with no idle cycle between them.

---
 rtl/p2s_lane_serializer.sv | 133 +++++++++++++
 tb/tb_p2s_lane_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_lane_serializer.sv
// rtl/p2s_lane_serializer.sv - parallel-to-serial lane serializer with one-word hold buffer
//
// Takes an N-bit word on a valid/ready parallel port and emits it as B = N/W
// beats of W bits on a valid/ready serial port. A one-word hold buffer lets a
// following word wait while the current one drains. A word offered during the
// last beat of the current word goes straight into the shifter, so consecutive
// words stream without an idle cycle.
//
// Parameters:
//   N         parallel word width (N % W == 0)
//   W         serial lane width, 1 <= W <= N
//   MSB_FIRST 0: lowest-indexed lane first, 1: highest-indexed lane first
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset; discards in-flight and held words
//   p_data   in   [N] parallel word
//   p_valid  in   p_data valid
//   p_ready  out  word can be accepted (hold buffer empty, registered)
//   s_data   out  [W] current serial beat
//   s_valid  out  s_data valid (shifter loaded)
//   s_ready  in   downstream accepts the beat
//   busy     out  shifter loaded or hold buffer full
//   s_last   out  final beat of a word (only when P2S_LAST_EN is defined)
//
// Optional feature macro: P2S_LAST_EN adds the s_last output.

module p2s_lane_serializer #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] p_data,
  input  logic         p_valid,
  output logic         p_ready,
  output logic [W-1:0] s_data,
  output logic         s_valid,
  input  logic         s_ready,
  output logic         busy
`ifdef P2S_LAST_EN
  ,
  output logic         s_last
`endif
);

  localparam int B  = N / W;
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(B - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TX   = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [N-1:0]  shifter;
  logic [N-1:0]  shifted;
  logic [N-1:0]  hold_data;
  logic          hold_full;

  logic beat_fire;
  logic last_fire;
  logic accept;
  logic bypass;
  logic to_hold;

  assign s_valid   = (state == ST_TX);
  assign p_ready   = !hold_full;
  assign busy      = s_valid || hold_full;

  assign beat_fire = s_valid && s_ready;
  assign last_fire = beat_fire && (count == LAST_CNT);
  assign accept    = p_valid && p_ready;
  // A word can skip the hold buffer when the shifter is empty or frees up this
  // cycle. While hold is full p_ready is low, so accept already implies an
  // empty hold buffer and hold always has priority for the next load.
  assign bypass    = accept && (!s_valid || last_fire);
  assign to_hold   = accept && !bypass;

  generate
    if (MSB_FIRST) begin : g_msb
      assign s_data  = shifter[N-1 -: W];
      assign shifted = shifter << W;
    end else begin : g_lsb
      assign s_data  = shifter[W-1:0];
      assign shifted = shifter >> W;
    end
  endgenerate

`ifdef P2S_LAST_EN
  assign s_last = s_valid && (count == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      count     <= '0;
      shifter   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (last_fire) begin
        count <= '0;
        if (hold_full) begin
          shifter   <= hold_data;
          hold_full <= 1'b0;
        end else if (bypass) begin
          shifter <= p_data;
        end else begin
          // Clear the shifter so s_data reads zero while idle.
          shifter <= '0;
          state   <= ST_IDLE;
        end
      end else if (beat_fire) begin
        shifter <= shifted;
        count   <= count + CW'(1);
      end else if (bypass) begin
        // Only reachable from IDLE: a loaded shifter bypasses only on its last beat.
        shifter <= p_data;
        count   <= '0;
        state   <= ST_TX;
      end

      // Never coincides with the hold drain above, since accept needs hold empty.
      if (to_hold) begin
        hold_data <= p_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_p2s_lane_serializer.sv
// tb/tb_p2s_lane_serializer.sv - self-checking bench for p2s_lane_serializer
//
// Four instances share clk/rstn:
//   u0: N=4 W=1 LSB-first, u1: N=8 W=2 LSB-first, u2: N=8 W=2 MSB-first,
//   u3: N=8 W=8. One instance is active at a time.
// Words are queued on in_q; when a word is accepted, its expected beats are
// pushed to exp_q. Each transferred beat is popped and compared.

module tb_p2s_lane_serializer;

  typedef struct {
    int          sel;
    logic [7:0]  word;
    int          nb;
    logic [31:0] beats;   // beat i in beats[8*i +: 8]
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       pv [4];
  logic       sr [4];
  logic [3:0] pd0;
  logic [7:0] pd1, pd2, pd3;
  logic       pr0, pr1, pr2, pr3;
  logic       sv0, sv1, sv2, sv3;
  logic       by0, by1, by2, by3;
  logic [0:0] sd0;
  logic [1:0] sd1, sd2;
  logic [7:0] sd3;
`ifdef P2S_LAST_EN
  logic       sl0, sl1, sl2, sl3;
`endif

  p2s_lane_serializer #(.N(4), .W(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .p_data(pd0), .p_valid(pv[0]), .p_ready(pr0),
    .s_data(sd0), .s_valid(sv0), .s_ready(sr[0]), .busy(by0)
`ifdef P2S_LAST_EN
    , .s_last(sl0)
`endif
  );
  p2s_lane_serializer #(.N(8), .W(2), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rstn(rstn), .p_data(pd1), .p_valid(pv[1]), .p_ready(pr1),
    .s_data(sd1), .s_valid(sv1), .s_ready(sr[1]), .busy(by1)
`ifdef P2S_LAST_EN
    , .s_last(sl1)
`endif
  );
  p2s_lane_serializer #(.N(8), .W(2), .MSB_FIRST(1'b1)) u2 (
    .clk(clk), .rstn(rstn), .p_data(pd2), .p_valid(pv[2]), .p_ready(pr2),
    .s_data(sd2), .s_valid(sv2), .s_ready(sr[2]), .busy(by2)
`ifdef P2S_LAST_EN
    , .s_last(sl2)
`endif
  );
  p2s_lane_serializer #(.N(8), .W(8), .MSB_FIRST(1'b0)) u3 (
    .clk(clk), .rstn(rstn), .p_data(pd3), .p_valid(pv[3]), .p_ready(pr3),
    .s_data(sd3), .s_valid(sv3), .s_ready(sr[3]), .busy(by3)
`ifdef P2S_LAST_EN
    , .s_last(sl3)
`endif
  );

  int errors = 0;
  int checks = 0;
  int act = 0;
  int vcnt = 0;
  int gap = 0;
  int prl = 0;
  vec_t in_q[$];
  logic [8:0] exp_q[$];
  vec_t tbl[4];

  // Packed outputs of instance k: [7:0] s_data, [8] p_ready, [9] s_valid, [10] busy, [11] s_last
  function automatic logic [11:0] outs(input int k);
    logic [11:0] o;
    logic sl;
    sl = 1'b0;
    o  = '0;
    case (k)
      0: begin o = {1'b0, by0, sv0, pr0, 7'b0, sd0};
`ifdef P2S_LAST_EN
         sl = sl0;
`endif
      end
      1: begin o = {1'b0, by1, sv1, pr1, 6'b0, sd1};
`ifdef P2S_LAST_EN
         sl = sl1;
`endif
      end
      2: begin o = {1'b0, by2, sv2, pr2, 6'b0, sd2};
`ifdef P2S_LAST_EN
         sl = sl2;
`endif
      end
      default: begin o = {1'b0, by3, sv3, pr3, sd3};
`ifdef P2S_LAST_EN
         sl = sl3;
`endif
      end
    endcase
    o[11] = sl;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic drive_word(input int k, input logic v, input logic [7:0] w);
    pv[k] = v;
    case (k)
      0: pd0 = w[3:0];
      1: pd1 = w;
      2: pd2 = w;
      default: pd3 = w;
    endcase
  endtask

  // One clock: monitor at negedge, then drive the next stimulus 1ns after posedge.
  task automatic tick();
    logic [11:0] o;
    logic [8:0]  e;
    vec_t        v;
    @(negedge clk);
    o = outs(act);
    if (o[9] && sr[act]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got 0x%0h expected none at %0t", o[7:0], $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {24'b0, o[7:0]}, {24'b0, e[7:0]});
`ifdef P2S_LAST_EN
        chk("last", {31'b0, o[11]}, {31'b0, e[8]});
`endif
      end
    end
    if (o[9]) vcnt++;
    else if (vcnt > 0 && exp_q.size() > 0) gap++;
    if (!o[8]) prl++;
    if (pv[act] && o[8] && in_q.size() > 0) begin
      v = in_q.pop_front();
      for (int i = 0; i < v.nb; i++)
        exp_q.push_back({(i == v.nb - 1), v.beats[8*i +: 8]});
    end
    @(posedge clk);
    #1;
    if (in_q.size() > 0) drive_word(act, 1'b1, in_q[0].word);
    else drive_word(act, 1'b0, 8'h00);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    chk({name, "_pending"}, exp_q.size() + in_q.size(), 0);
  endtask

  function automatic vec_t mk(input int s, input logic [7:0] w, input int nb, input logic [31:0] b);
    vec_t v;
    v.sel = s; v.word = w; v.nb = nb; v.beats = b;
    return v;
  endfunction

  initial begin
    logic [11:0] o;
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0;
      sr[k] = 1'b1;
    end
    pd0 = '0; pd1 = '0; pd2 = '0; pd3 = '0;

    tbl[0] = mk(0, 8'h06, 4, 32'h00010100);   // beats 0,1,1,0
    tbl[1] = mk(1, 8'hB4, 4, 32'h02030100);   // beats 0,1,3,2
    tbl[2] = mk(2, 8'hB4, 4, 32'h00010302);   // beats 2,3,1,0
    tbl[3] = mk(3, 8'h5A, 1, 32'h0000005A);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      o = outs(k);
      chk("rst_p_ready", {31'b0, o[8]}, 1);
      chk("rst_s_valid", {31'b0, o[9]}, 0);
      chk("rst_busy", {31'b0, o[10]}, 0);
      chk("rst_s_data", {24'b0, o[7:0]}, 0);
    end

    // Table-driven single words
    for (int i = 0; i < 4; i++) begin
      act = tbl[i].sel;
      vcnt = 0; gap = 0;
      in_q.push_back(tbl[i]);
      drain("vec");
      chk("vec_beats", vcnt, tbl[i].nb);
      chk("vec_gap", gap, 0);
    end

    // Back-to-back on N=8 W=2
    act = 1; vcnt = 0; gap = 0; prl = 0;
    in_q.push_back(mk(1, 8'h12, 4, 32'h00010002));
    in_q.push_back(mk(1, 8'h34, 4, 32'h00030100));
    in_q.push_back(mk(1, 8'h56, 4, 32'h01010102));
    drain("b2b");
    chk("b2b_beats", vcnt, 12);
    chk("b2b_gap", gap, 0);
    chk("b2b_pready_low_cycles", prl, 6);
    o = outs(1);
    chk("b2b_busy_after", {31'b0, o[10]}, 0);
    chk("b2b_valid_after", {31'b0, o[9]}, 0);

    // Backpressure mid-word with a second word arriving during the stall
    act = 1; sr[1] = 1'b1;
    in_q.push_back(mk(1, 8'hB4, 4, 32'h02030100));
    repeat (4) tick();
    sr[1] = 1'b0;
    in_q.push_back(mk(1, 8'h12, 4, 32'h00010002));
    for (int i = 0; i < 3; i++) begin
      tick();
      o = outs(1);
      chk("bp_s_data", {24'b0, o[7:0]}, 3);
      chk("bp_s_valid", {31'b0, o[9]}, 1);
    end
    chk("bp_p_ready", {31'b0, o[8]}, 0);
    sr[1] = 1'b1;
    drain("bp");

    // Asynchronous reset mid-word with hold full
    act = 1;
    in_q.push_back(mk(1, 8'hB4, 4, 32'h02030100));
    in_q.push_back(mk(1, 8'h34, 4, 32'h00030100));
    repeat (4) tick();
    o = outs(1);
    chk("pre_rst_hold_full", {31'b0, o[8]}, 0);
    #3 rstn = 1'b0;
    #1;
    o = outs(1);
    chk("mid_rst_s_valid", {31'b0, o[9]}, 0);
    chk("mid_rst_p_ready", {31'b0, o[8]}, 1);
    chk("mid_rst_busy", {31'b0, o[10]}, 0);
    drive_word(1, 1'b0, 8'h00);
    in_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    vcnt = 0;
    in_q.push_back(mk(1, 8'hA5, 4, 32'h02020101));   // beats 1,1,2,2
    drain("post_rst");
    chk("post_rst_beats", vcnt, 4);

    // W = N: one word per cycle through the bypass path
    act = 3; vcnt = 0; gap = 0; prl = 0;
    for (int i = 1; i <= 4; i++)
      in_q.push_back(mk(3, 8'(i), 1, 32'(i)));
    drain("wide");
    chk("wide_beats", vcnt, 4);
    chk("wide_gap", gap, 0);
    chk("wide_pready_low", prl, 0);
    o = outs(3);
    chk("wide_busy_after", {31'b0, o[10]}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
